// File: rtl/cache_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_ctrl_if : CPU request/response, cache and backing-memory buses  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface cache_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  req_ready;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  c_we;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic [DATA_WIDTH-1:0] c_rdata;
  logic                  c_hit;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // master is the controller; slave is the CPU/cache/memory environment
  modport master (
    input  req_valid, req_we, req_addr, req_wdata, c_rdata, c_hit, mem_ack, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, c_we, c_addr, c_wdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, c_rdata, c_hit, mem_ack, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, c_we, c_addr, c_wdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/cache_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_ctrl : single-request write-through cache controller with      |
// |              bounded backing-memory wait                             |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module cache_ctrl #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_TIMEOUT = 255
) (
  input  wire logic     clk,
  input  wire logic     rst,
  cache_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_CHECK  = 3'd2,
    ST_MEM_RD = 3'd3,
    ST_MEM_WR = 3'd4,
    ST_FILL   = 3'd5,
    ST_RESP   = 3'd6
  } state_t;

  // timeout fires on the cycle whose increment would bring the count to MEM_TIMEOUT
  localparam logic [7:0] c_wait_last = 8'(MEM_TIMEOUT - 1);

  state_t                r_state;
  logic [7:0]            r_wait;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;

  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;
  logic                  r_c_we;
  logic [ADDR_WIDTH-1:0] r_c_addr;
  logic [DATA_WIDTH-1:0] r_c_wdata;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.c_we      = r_c_we;
  assign bus.c_addr    = r_c_addr;
  assign bus.c_wdata   = r_c_wdata;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_wait      <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_c_we      <= 1'b0;
      r_c_addr    <= '0;
      r_c_wdata   <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_addr      <= bus.req_addr;
            r_data      <= bus.req_wdata;
            r_req_ready <= 1'b0;
            if (bus.req_we) begin
              // stores bypass the lookup and write through to memory first
              r_state     <= ST_MEM_WR;
              r_wait      <= '0;
              r_mem_req   <= 1'b1;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= bus.req_addr;
              r_mem_wdata <= bus.req_wdata;
            end else begin
              r_state  <= ST_LOOKUP;
              r_c_addr <= bus.req_addr;
            end
          end
        end

        ST_LOOKUP: begin
          r_state <= ST_CHECK;
        end

        ST_CHECK: begin
          if (bus.c_hit) begin
            r_data      <= bus.c_rdata;
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= bus.c_rdata;
            r_rsp_err   <= 1'b0;
          end else begin
            r_state     <= ST_MEM_RD;
            r_wait      <= '0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= '0;
          end
        end

        ST_MEM_RD, ST_MEM_WR: begin
          if (bus.mem_ack) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_state     <= ST_FILL;
            r_c_we      <= 1'b1;
            r_c_addr    <= r_addr;
            if (r_state == ST_MEM_RD) begin
              r_data    <= bus.mem_rdata;
              r_c_wdata <= bus.mem_rdata;
            end else begin
              r_c_wdata <= r_data;
            end
          end else if (r_wait == c_wait_last) begin
            r_wait      <= r_wait + 8'd1;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end

        ST_FILL: begin
          r_c_we      <= 1'b0;
          r_c_wdata   <= '0;
          r_state     <= ST_RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= r_data;
          r_rsp_err   <= 1'b0;
        end

        ST_RESP: begin
          r_rsp_valid <= 1'b0;
          r_rsp_rdata <= '0;
          r_rsp_err   <= 1'b0;
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
        end

        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_c_we      <= 1'b0;
          r_mem_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cache_ctrl : directed scoreboard bench for cache_ctrl             |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_cache_ctrl;
  localparam int c_aw      = 8;
  localparam int c_dw      = 8;
  localparam int c_timeout = 255;
  localparam int K_ABS     = 0;
  localparam int K_FILL    = 1;
  localparam int K_NONE    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  initial forever #5 clk = ~clk;

  cache_ctrl_if #(.ADDR_WIDTH(c_aw), .DATA_WIDTH(c_dw)) bus();

  cache_ctrl #(.ADDR_WIDTH(c_aw), .DATA_WIDTH(c_dw), .MEM_TIMEOUT(c_timeout)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { logic [7:0] rdata; logic err; int kind; } rsp_t;
  typedef struct { logic [7:0] addr; logic [7:0] data; } fill_t;
  typedef struct { logic we; logic [7:0] addr; logic [7:0] wdata; } memx_t;

  rsp_t  resp_q[$];
  fill_t fill_q[$];
  memx_t mem_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0, acc_cyc = 0, fill_cyc = 0;
  int mem_len = 0, last_mem_len = 0, mem_total = 0, cwe_total = 0;
  logic prev_mem_req = 1'b0, prev_c_we = 1'b0, prev_rsp = 1'b0;
  logic [8:0] mem_first = '0;
  rsp_t  mon_r;
  fill_t mon_f;
  memx_t mon_m;

  // small cache: entry 0x10 preloaded, filled by c_we, hit/data registered on c_addr
  logic       cache_vld  [256] = '{default: 1'b0};
  logic [7:0] cache_data [256] = '{default: 8'h00};
  always @(posedge clk) begin
    if (!rst) begin
      cache_vld[8'h10]  <= 1'b1;
      cache_data[8'h10] <= 8'h5A;
    end else if (bus.c_we) begin
      cache_vld[bus.c_addr]  <= 1'b1;
      cache_data[bus.c_addr] <= bus.c_wdata;
    end
    bus.c_hit   <= cache_vld[bus.c_addr];
    bus.c_rdata <= cache_data[bus.c_addr];
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitor: pops the scoreboard whenever the DUT presents c_we, mem_req or rsp_valid
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      prev_mem_req = 1'b0;
      prev_c_we    = 1'b0;
      prev_rsp     = 1'b0;
      mem_len      = 0;
    end else begin
      if (bus.req_valid && bus.req_ready) acc_cyc = cyc + 1;

      if (bus.c_we) begin
        cwe_total++;
        checks++;
        if (prev_c_we) begin
          errors++;
          $display("FAIL c_we_pulse: c_we high for 2+ cycles, expected 1 (cycle %0d)", cyc);
        end else if (fill_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_c_we: c_we=1 addr=0x%0h, expected no fill", bus.c_addr);
        end else begin
          mon_f = fill_q.pop_front();
          chk("fill_addr", int'(bus.c_addr), int'(mon_f.addr));
          chk("fill_data", int'(bus.c_wdata), int'(mon_f.data));
          fill_cyc = cyc;
        end
      end

      if (bus.mem_req) begin
        mem_total++;
        if (!prev_mem_req) begin
          mem_len   = 1;
          mem_first = {bus.mem_we, bus.mem_addr};
          checks++;
          if (mem_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_mem_req: mem_req=1 addr=0x%0h, expected none", bus.mem_addr);
          end else begin
            mon_m = mem_q.pop_front();
            chk("mem_we", int'(bus.mem_we), int'(mon_m.we));
            chk("mem_addr", int'(bus.mem_addr), int'(mon_m.addr));
            if (mon_m.we) chk("mem_wdata", int'(bus.mem_wdata), int'(mon_m.wdata));
          end
        end else begin
          mem_len++;
          chk("mem_stable", int'({bus.mem_we, bus.mem_addr}), int'(mem_first));
        end
      end else if (prev_mem_req) begin
        last_mem_len = mem_len;
      end

      if (bus.rsp_valid) begin
        checks++;
        if (prev_rsp) begin
          errors++;
          $display("FAIL rsp_pulse: rsp_valid high for 2+ cycles, expected 1 (cycle %0d)", cyc);
        end else if (resp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: rsp_valid=1 rdata=0x%0h, expected none", bus.rsp_rdata);
        end else begin
          mon_r = resp_q.pop_front();
          chk("rsp_rdata", int'(bus.rsp_rdata), int'(mon_r.rdata));
          chk("rsp_err", int'(bus.rsp_err), int'(mon_r.err));
          if (mon_r.kind == K_ABS)       chk("hit_latency", cyc - acc_cyc, 2);
          else if (mon_r.kind == K_FILL) chk("fill_to_rsp", cyc - fill_cyc, 1);
        end
      end

      prev_mem_req = bus.mem_req;
      prev_c_we    = bus.c_we;
      prev_rsp     = bus.rsp_valid;
    end
  end

  task automatic issue(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    int n = 0;
    while (!bus.req_ready && n < 20) begin step(); n++; end
    checks++;
    if (!bus.req_ready) begin
      errors++;
      $display("FAIL ready_wait: req_ready=0 after %0d cycles, expected 1", n);
    end
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    step();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic mem_serve(input int wait_cyc, input bit do_ack, input logic [7:0] rdata);
    int n = 0;
    while (!bus.mem_req && n < 20) begin step(); n++; end
    checks++;
    if (!bus.mem_req) begin
      errors++;
      $display("FAIL mem_req_start: mem_req=0 after %0d cycles, expected 1", n);
    end else begin
      repeat (wait_cyc) step();
      if (do_ack) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
        step();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
      end
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (resp_q.size() != 0 && n < 400) begin step(); n++; end
    checks++;
    if (resp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d responses pending, expected 0", name, resp_q.size());
      resp_q.delete();
      fill_q.delete();
      mem_q.delete();
    end
    step();
  endtask

  initial begin
    int before_mem;
    int before_cwe;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;

    repeat (3) step();
    chk("rst_req_ready", int'(bus.req_ready), 1);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_c_we", int'(bus.c_we), 0);
    chk("rst_mem_req", int'(bus.mem_req), 0);
    chk("rst_rsp_rdata", int'(bus.rsp_rdata), 0);
    rst = 1'b1;
    chk("ready_after_rst", int'(bus.req_ready), 1);
    step();

    // load hit
    before_mem = mem_total;
    resp_q.push_back('{rdata: 8'h5A, err: 1'b0, kind: K_ABS});
    issue(1'b0, 8'h10, 8'h00);
    wait_done("hit_10");
    chk("hit_no_mem_req", mem_total, before_mem);

    // load miss, ack after 4 cycles
    mem_q.push_back('{we: 1'b0, addr: 8'h20, wdata: 8'h00});
    fill_q.push_back('{addr: 8'h20, data: 8'h3C});
    resp_q.push_back('{rdata: 8'h3C, err: 1'b0, kind: K_FILL});
    issue(1'b0, 8'h20, 8'h00);
    mem_serve(4, 1'b1, 8'h3C);
    wait_done("miss_20");
    chk("miss_mem_len", last_mem_len, 5);

    // the filled line now hits
    resp_q.push_back('{rdata: 8'h3C, err: 1'b0, kind: K_ABS});
    issue(1'b0, 8'h20, 8'h00);
    wait_done("hit_20");

    // store, ack after 2 cycles
    mem_q.push_back('{we: 1'b1, addr: 8'h30, wdata: 8'hA7});
    fill_q.push_back('{addr: 8'h30, data: 8'hA7});
    resp_q.push_back('{rdata: 8'hA7, err: 1'b0, kind: K_FILL});
    issue(1'b1, 8'h30, 8'hA7);
    mem_serve(2, 1'b1, 8'h00);
    wait_done("store_30");
    chk("store_mem_len", last_mem_len, 3);

    // timeout with no ack
    before_cwe = cwe_total;
    mem_q.push_back('{we: 1'b0, addr: 8'h40, wdata: 8'h00});
    resp_q.push_back('{rdata: 8'h00, err: 1'b1, kind: K_NONE});
    issue(1'b0, 8'h40, 8'h00);
    mem_serve(0, 1'b0, 8'h00);
    wait_done("timeout_40");
    chk("timeout_mem_len", last_mem_len, c_timeout);
    chk("timeout_no_c_we", cwe_total, before_cwe);

    // ack on the timeout cycle wins
    mem_q.push_back('{we: 1'b0, addr: 8'h50, wdata: 8'h00});
    fill_q.push_back('{addr: 8'h50, data: 8'h99});
    resp_q.push_back('{rdata: 8'h99, err: 1'b0, kind: K_FILL});
    issue(1'b0, 8'h50, 8'h00);
    mem_serve(c_timeout - 1, 1'b1, 8'h99);
    wait_done("ack_at_timeout");
    chk("ack_at_timeout_len", last_mem_len, c_timeout);

    // request while busy and stray mem_ack in IDLE are ignored
    before_mem = mem_total;
    before_cwe = cwe_total;
    resp_q.push_back('{rdata: 8'h5A, err: 1'b0, kind: K_ABS});
    issue(1'b0, 8'h10, 8'h00);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 8'h77;
    bus.req_wdata = 8'h11;
    step();
    step();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    wait_done("busy_ignore");
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 8'hEE;
    step();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    repeat (4) step();
    chk("ignore_mem_total", mem_total, before_mem);
    chk("ignore_c_we", cwe_total, before_cwe);
    chk("ignore_ready", int'(bus.req_ready), 1);

    // reset during MEM_RD aborts silently
    mem_q.push_back('{we: 1'b0, addr: 8'h60, wdata: 8'h00});
    issue(1'b0, 8'h60, 8'h00);
    mem_serve(2, 1'b0, 8'h00);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_mem_req", int'(bus.mem_req), 0);
    chk("async_rst_ready", int'(bus.req_ready), 1);
    chk("async_rst_mem_addr", int'(bus.mem_addr), 0);
    chk("async_rst_rsp_valid", int'(bus.rsp_valid), 0);
    step();
    rst = 1'b1;
    chk("ready_after_abort", int'(bus.req_ready), 1);
    repeat (6) step();

    resp_q.push_back('{rdata: 8'h5A, err: 1'b0, kind: K_ABS});
    issue(1'b0, 8'h10, 8'h00);
    wait_done("hit_after_rst");

    chk("fill_q_empty", fill_q.size(), 0);
    chk("mem_q_empty", mem_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
